// File: rtl/regfile_pkg.sv
// Shared constants, default-configuration types and the port-priority helper
// used by the multi-port register file.
package regfile_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_REGS_DEF = 32;
    localparam int MAX_PORTS    = 16;
    localparam int PORT_IDX_W   = $clog2(MAX_PORTS);

    typedef logic [$clog2(NUM_REGS_DEF)-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0]           reg_data_t;

    typedef struct packed {
        logic                  hit;
        logic [PORT_IDX_W-1:0] idx;
    } port_match_t;

    // Scans upward so the highest-index matching port overrides lower ones.
    function automatic port_match_t highest_match(input logic [MAX_PORTS-1:0] matchVec);
        port_match_t res;
        res.hit = 1'b0;
        res.idx = '0;
        for (int p = 0; p < MAX_PORTS; p++) begin
            if (matchVec[p]) begin
                res.hit = 1'b1;
                res.idx = PORT_IDX_W'(p);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/regfile_mp_scoreboard.sv
// Per-register busy scoreboard: producers set a bit at issue, writeback clears it.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_WR-1:0]              wr_en_i,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr_i,
    input  logic                           bsy_set_i,
    input  logic [ADDR_W-1:0]              bsy_addr_i,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr_i,
    output logic [NUM_RD-1:0]              rd_busy_o,
    output logic [NUM_REGS-1:0]            busy_o
);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_clr;
    logic [NUM_REGS-1:0] w_busyNext;

    // A set on the same edge as a clear wins: the new producer re-claims the register.
    always_comb begin
        w_clr      = '0;
        w_busyNext = '0;
        for (int a = 0; a < NUM_REGS; a++) begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en_i[p] && (wr_addr_i[p] == ADDR_W'(a))) begin
                    w_clr[a] = 1'b1;
                end
            end
            w_busyNext[a] = (bsy_set_i && (bsy_addr_i == ADDR_W'(a))) || (r_busy[a] && !w_clr[a]);
        end
        if (ZERO_REG != 0) begin
            w_busyNext[0] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    always_comb begin
        rd_busy_o = '0;
        for (int r = 0; r < NUM_RD; r++) begin
            rd_busy_o[r] = r_busy[rd_addr_i[r]]
                           && !((BYPASS != 0) && !rst_i && w_clr[rd_addr_i[r]]);
        end
    end

    assign busy_o = r_busy;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with write-to-read bypass, write-port
// priority, optional hardwired zero register and a busy scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int NUM_REGS = NUM_REGS_DEF,
    parameter  int NUM_RD   = 2,
    parameter  int NUM_WR   = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_RD-1:0][ADDR_W-1:0]  rd_addr_i,
    output logic [NUM_RD-1:0][DATA_W-1:0]  rd_data_o,
    output logic [NUM_RD-1:0]              rd_busy_o,
    input  logic [NUM_WR-1:0]              wr_en_i,
    input  logic [NUM_WR-1:0][ADDR_W-1:0]  wr_addr_i,
    input  logic [NUM_WR-1:0][DATA_W-1:0]  wr_data_i,
    input  logic                           bsy_set_i,
    input  logic [ADDR_W-1:0]              bsy_addr_i,
    output logic [NUM_REGS-1:0]            busy_o
);

    logic [DATA_W-1:0]    r_regs [NUM_REGS];
    logic [NUM_WR-1:0]    w_wrValid;
    logic [MAX_PORTS-1:0] w_hitVec [NUM_RD];
    port_match_t          w_match  [NUM_RD];

    always_comb begin
        w_wrValid = '0;
        for (int p = 0; p < NUM_WR; p++) begin
            w_wrValid[p] = wr_en_i[p] && !((ZERO_REG != 0) && (wr_addr_i[p] == '0));
        end
    end

    // Later ports are assigned last, so the highest-index port wins a collision.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_WR; p++) begin
                if (w_wrValid[p]) begin
                    r_regs[wr_addr_i[p]] <= wr_data_i[p];
                end
            end
        end
    end

    always_comb begin
        for (int r = 0; r < NUM_RD; r++) begin
            w_hitVec[r] = '0;
            for (int p = 0; p < NUM_WR; p++) begin
                w_hitVec[r][p] = w_wrValid[p] && (wr_addr_i[p] == rd_addr_i[r]);
            end
            w_match[r] = highest_match(w_hitVec[r]);

            if ((ZERO_REG != 0) && (rd_addr_i[r] == '0)) begin
                rd_data_o[r] = '0;
            end else begin
                rd_data_o[r] = r_regs[rd_addr_i[r]];
            end

            // Forwarding is held off during reset so held outputs stay zero.
            if ((BYPASS != 0) && !rst_i && w_match[r].hit) begin
                for (int p = 0; p < NUM_WR; p++) begin
                    if (w_match[r].idx == PORT_IDX_W'(p)) begin
                        rd_data_o[r] = wr_data_i[p];
                    end
                end
            end
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_RD   (NUM_RD),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .bsy_set_i  (bsy_set_i),
        .bsy_addr_i (bsy_addr_i),
        .rd_addr_i  (rd_addr_i),
        .rd_busy_o  (rd_busy_o),
        .busy_o     (busy_o)
    );

endmodule
